// File: rtl/bcd_adder.sv
// Multi-digit packed-BCD adder with a single registered output stage.
// Digit carries ripple combinationally. Non-BCD digits still go through
// the same +6 correction and set err for that result.
module bcd_adder #(
    parameter int unsigned DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  carry,
    output logic                  out_valid,
    output logic                  err
);

    localparam int unsigned DW = 4;
    localparam int unsigned W  = DW * DIGITS;

    logic [W-1:0]  sum_c;
    logic          carry_c;
    logic          err_c;
    logic          dig_carry;
    logic [DW:0]   dig_sum;
    logic [DW-1:0] dig_a;
    logic [DW-1:0] dig_b;

    // Ripple decimal addition across all digits; flag any digit above 9.
    always_comb begin
        sum_c     = '0;
        err_c     = 1'b0;
        dig_carry = cin;
        dig_sum   = '0;
        dig_a     = '0;
        dig_b     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig_a   = a[DW*i +: DW];
            dig_b   = b[DW*i +: DW];
            dig_sum = (DW+1)'(dig_a) + (DW+1)'(dig_b) + (DW+1)'(dig_carry);
            if (dig_sum >= (DW+1)'(10)) begin
                sum_c[DW*i +: DW] = DW'(dig_sum + (DW+1)'(6));
                dig_carry         = 1'b1;
            end else begin
                sum_c[DW*i +: DW] = dig_sum[DW-1:0];
                dig_carry         = 1'b0;
            end
            if ((dig_a > DW'(9)) || (dig_b > DW'(9))) begin
                err_c = 1'b1;
            end
        end
        carry_c = dig_carry;
    end

    // Output register: capture on accepted operands, otherwise hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_c;
                carry <= carry_c;
                err   <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_bcd_adder.sv
// Directed bench for bcd_adder: one-digit and two-digit instances.
module tb_bcd_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       iv1 = 1'b0;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic [3:0] sum1;
    logic       carry1, ov1, err1;

    logic       iv2 = 1'b0;
    logic [7:0] a2 = '0;
    logic [7:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic [7:0] sum2;
    logic       carry2, ov2, err2;

    int vectors = 0;
    int miscompares = 0;

    bcd_adder #(.DIGITS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .carry(carry1), .out_valid(ov1), .err(err1)
    );

    bcd_adder #(.DIGITS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .a(a2), .b(b2), .cin(cin2),
        .sum(sum2), .carry(carry2), .out_valid(ov2), .err(err2)
    );

    always #5 clk = ~clk;

    // Observed words are {out_valid, err, carry, sum}.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w1();
        return 32'({ov1, err1, carry1, sum1});
    endfunction

    function automatic logic [31:0] w2();
        return 32'({ov2, err2, carry2, sum2});
    endfunction

    task automatic step1(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        @(negedge clk);
        a1 = ta; b1 = tb; cin1 = tc; iv1 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a2 = ta; b2 = tb; cin2 = tc; iv2 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        iv1 = 1'b0; iv2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        // Reset state
        @(posedge clk); #1;
        chk("reset_d1", w1(), 32'h0);
        chk("reset_d2", w2(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-digit directed vectors, back to back
        step1(4'd5, 4'd3, 1'b0);
        chk("d1_5p3", w1(), 32'({1'b1, 1'b0, 1'b0, 4'd8}));
        step1(4'd7, 4'd8, 1'b1);
        chk("d1_7p8p1", w1(), 32'({1'b1, 1'b0, 1'b1, 4'd6}));
        step1(4'd9, 4'd9, 1'b1);
        chk("d1_9p9p1", w1(), 32'({1'b1, 1'b0, 1'b1, 4'd9}));
        step1(4'd15, 4'd15, 1'b1);
        chk("d1_illegal_max", w1(), 32'({1'b1, 1'b1, 1'b1, 4'd5}));
        step1(4'd12, 4'd3, 1'b0);
        chk("d1_illegal_12p3", w1(), 32'({1'b1, 1'b1, 1'b1, 4'd5}));

        // Hold for three idle cycles
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("d1_hold", w1(), 32'({1'b0, 1'b1, 1'b1, 4'd5}));
        end

        // Two-digit ripple vectors
        step2(8'h99, 8'h01, 1'b0);
        chk("d2_99p01", w2(), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
        step2(8'h45, 8'h37, 1'b1);
        chk("d2_45p37p1", w2(), 32'({1'b1, 1'b0, 1'b0, 8'h83}));
        step2(8'hA0, 8'h00, 1'b0);
        chk("d2_illegal_hi", w2(), 32'({1'b1, 1'b1, 1'b1, 8'h00}));
        step2(8'h50, 8'h49, 1'b1);
        chk("d2_50p49p1", w2(), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
        idle();
        chk("d2_hold", w2(), 32'({1'b0, 1'b0, 1'b1, 8'h00}));

        // Asynchronous reset while a result is valid
        step1(4'd4, 4'd4, 1'b0);
        chk("d1_4p4", w1(), 32'({1'b1, 1'b0, 1'b0, 4'd8}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_d1", w1(), 32'h0);
        chk("async_reset_d2", w2(), 32'h0);
        // Operands offered while reset is held must not be captured
        @(negedge clk);
        a1 = 4'd5; b1 = 4'd3; cin1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        chk("reset_no_capture", w1(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; iv1 = 1'b0;
        @(posedge clk); #1;
        chk("post_release_idle", w1(), 32'h0);

        // Exhaustive legal one-digit triples
        for (int ai = 0; ai < 10; ai++) begin
            for (int bi = 0; bi < 10; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    step1(4'(ai), 4'(bi), 1'(ci));
                    v = ai + bi + ci;
                    chk($sformatf("exh_%0d_%0d_%0d", ai, bi, ci), w1(),
                        32'({1'b1, 1'b0, (v >= 10) ? 1'b1 : 1'b0, 4'(v % 10)}));
                end
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_adder.md
BCD_ADDER -- requirements
Module: bcd_adder

Interface
REQ-001 Parameter: DIGITS, default 1, number of 4-bit BCD digits per operand (legal range 1..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operands a, b, cin qualified this cycle.
REQ-005 Port: a  input  4*DIGITS  addend, packed BCD, digit 0 in bits [3:0].
REQ-006 Port: b  input  4*DIGITS  addend, packed BCD, same packing as a.
REQ-007 Port: cin  input  1  decimal carry-in into digit 0.
REQ-008 Port: sum  output  4*DIGITS  registered packed-BCD result.
REQ-009 Port: carry  output  1  registered decimal carry-out of the most significant digit.
REQ-010 Port: out_valid  output  1  sum/carry/err updated by the previous cycle's accepted operands.
REQ-011 Port: err  output  1  registered flag: at least one digit of a or b was greater than 9.

Function
REQ-012 Digit i SHALL form a 5-bit binary s_i = a_i + b_i + c_i, with c_0 = cin and c_(i+1) = carry of digit i.
REQ-013 If s_i >= 10, digit result SHALL be (s_i + 6) modulo 16 and digit carry SHALL be 1; otherwise the digit result SHALL be s_i[3:0] and the digit carry 0.
REQ-014 Digit carries SHALL ripple combinationally within one cycle across all DIGITS; carry = carry of digit DIGITS-1.
REQ-015 For legal BCD inputs, {carry, sum} SHALL equal the decimal value a + b + cin.
REQ-016 Non-BCD digits (10..15) SHALL still follow REQ-013 exactly (s_i up to 31), and err SHALL be 1 for that result.
REQ-017 Latency SHALL be exactly 1 cycle: operands sampled on edge N with in_valid=1 appear on sum/carry/err with out_valid=1 after edge N.
REQ-018 On an edge with in_valid=0: sum, carry and err SHALL hold their previous values, and out_valid SHALL be 0.
REQ-019 Back-to-back in_valid=1 SHALL be accepted every cycle with no stall; there is no backpressure input.
REQ-020 Outputs SHALL be driven only from registers (no combinational path from inputs to outputs).

Reset
REQ-021 While rst_n=0, sum SHALL be 0, carry 0, err 0 and out_valid 0, asynchronously and independent of clk.
REQ-022 Assertion of rst_n mid-operation SHALL discard the in-flight result; the first edge after deassertion with in_valid=1 SHALL produce a normal result one cycle later.
REQ-023 Release of rst_n is synchronous to clk from the design's point of view; no operand is captured on the edge where rst_n is still low.

Verification
REQ-024 DIGITS=1: a=5, b=3, cin=0, in_valid=1 -> next cycle sum=8, carry=0, err=0, out_valid=1.
REQ-025 DIGITS=1: a=7, b=8, cin=1 -> sum=6, carry=1, err=0; a=9, b=9, cin=1 -> sum=9, carry=1, err=0.
REQ-026 DIGITS=1 illegal: a=12, b=3, cin=0 -> s=15 -> sum=5, carry=1, err=1.
REQ-027 DIGITS=2 ripple: a=0x99, b=0x01, cin=0 -> sum=0x00, carry=1; a=0x45, b=0x37, cin=1 -> sum=0x83, carry=0.
REQ-028 Hold/valid: result captured, then in_valid=0 for 3 cycles -> out_valid=0, sum/carry/err unchanged.
REQ-029 Reset: drive rst_n=0 between clock edges while out_valid=1 -> sum, carry, err, out_valid go to 0 immediately; exhaustive check of all 200 legal (a, b, cin) triples for DIGITS=1 after release matches REQ-015.
